tt_proj_stepper: RTL and testbench

TT_PROJ_STEPPER -- requirements
Module: tt_proj_stepper

---
 rtl/tt_proj_stepper.sv | 186 ++++++++++++++++++
 tb/tb_tt_proj_stepper.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_proj_stepper.sv
// Command-driven stepper for a Tiny Tapeout style project: drives the project's
// clock, reset and inputs from a command port and returns a snapshot of its outputs.
module tt_proj_stepper #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned DIV        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_ui,
  input  logic [7:0]  cmd_uio,
  input  logic [7:0]  cmd_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_data,
  output logic        ena,
  output logic [17:0] iw,
  input  logic [23:0] ow
);

  localparam int unsigned CW   = 8;
  localparam int unsigned IW_W = 18;
  localparam int unsigned OW_W = 24;

  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES);

  localparam logic [1:0] OP_SAMPLE  = 2'b00;
  localparam logic [1:0] OP_RESET   = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_DISABLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RST_HI,
    RST_LO,
    RUN_HI,
    RUN_LO,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     half_q, half_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [IW_W-1:0]   iw_q, iw_d;
  logic              ena_q, ena_d;
  logic [OW_W-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;

  // State and output registers; reset parks the project in reset with its clock low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      half_q      <= '0;
      cyc_q       <= '0;
      iw_q        <= '0;
      ena_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      cyc_q       <= cyc_d;
      iw_q        <= iw_d;
      ena_q       <= ena_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    cyc_d      = cyc_q;
    iw_d       = iw_q;
    ena_d      = ena_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_SAMPLE: begin
              rsp_data_d = ow;
              state_d    = RESP;
            end
            OP_RESET: begin
              ena_d   = 1'b1;
              iw_d[1] = 1'b0;
              half_d  = HALF_LOAD;
              cyc_d   = RST_LOAD;
              state_d = RST_HI;
            end
            OP_STEP: begin
              iw_d[17:2] = {cmd_uio, cmd_ui};
              half_d     = HALF_LOAD;
              cyc_d      = cmd_count;
              // A zero-cycle step only settles inputs for one low half-period.
              state_d    = (cmd_count == '0) ? RUN_LO : RUN_HI;
            end
            OP_DISABLE: begin
              ena_d      = 1'b0;
              iw_d       = '0;
              rsp_data_d = ow;
              state_d    = RESP;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      RST_HI: begin
        if (half_q == '0) begin
          half_d  = HALF_LOAD;
          state_d = RST_LO;
        end else begin
          half_d = half_q - CW'(1);
        end
      end

      RST_LO: begin
        if (half_q != '0) begin
          half_d = half_q - CW'(1);
        end else if (cyc_q <= CW'(1)) begin
          cyc_d      = '0;
          iw_d[1]    = 1'b1;
          rsp_data_d = ow;
          state_d    = RESP;
        end else begin
          cyc_d   = cyc_q - CW'(1);
          half_d  = HALF_LOAD;
          state_d = RST_HI;
        end
      end

      RUN_HI: begin
        if (half_q == '0) begin
          half_d  = HALF_LOAD;
          state_d = RUN_LO;
        end else begin
          half_d = half_q - CW'(1);
        end
      end

      RUN_LO: begin
        if (half_q != '0) begin
          half_d = half_q - CW'(1);
        end else if (cyc_q <= CW'(1)) begin
          cyc_d      = '0;
          rsp_data_d = ow;
          state_d    = RESP;
        end else begin
          cyc_d   = cyc_q - CW'(1);
          half_d  = HALF_LOAD;
          state_d = RUN_HI;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The project clock follows the high phases only, so it is low in every other state.
    iw_d[0]     = (state_d == RST_HI) || (state_d == RUN_HI);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ena       = ena_q;
  assign iw        = iw_q;

endmodule

// File: tb/tb_tt_proj_stepper.sv
// Directed bench for tt_proj_stepper with a small project model counting clock rises.
module tb_tt_proj_stepper;

  localparam int unsigned DIV  = 2;
  localparam int unsigned RSTC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_ui;
  logic [7:0]  cmd_uio;
  logic [7:0]  cmd_count;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_data;
  logic        ena;
  logic [17:0] iw;
  logic [23:0] ow;

  int nvec = 0;
  int nerr = 0;

  tt_proj_stepper #(.RST_CYCLES(RSTC), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ui    (cmd_ui),
    .cmd_uio   (cmd_uio),
    .cmd_count (cmd_count),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ena       (ena),
    .iw        (iw),
    .ow        (ow)
  );

  always #5 clk = ~clk;

  // Project model: counts rising edges of its clock while out of reset.
  logic [7:0] edge_cnt;
  logic       iw0_prev;
  always @(posedge clk) begin
    iw0_prev <= iw[0];
    if (rst || !iw[1]) edge_cnt <= 8'h00;
    else if (iw[0] && !iw0_prev) edge_cnt <= edge_cnt + 8'h01;
  end
  assign ow = {8'hC3, iw[9:2], edge_cnt};

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] ui, input logic [7:0] uio,
                          input logic [7:0] cnt);
    int guard = 0;
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL send_ready got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ui    = ui;
    cmd_uio   = uio;
    cmd_count = cnt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if (iw !== 18'h0 || ena !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 24'h0) begin
      nerr++;
      $display("FAIL reset_vals iw=%h ena=%b rsp_valid=%b rsp_data=%h want 0/0/0/0",
               iw, ena, rsp_valid, rsp_data);
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ready cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_cmd();
    logic exp0;
    send_cmd(2'b01, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 2 * DIV * RSTC; k++) begin
      exp0 = ((k / DIV) % 2) == 0;
      nvec++;
      if (iw[0] !== exp0 || iw[1] !== 1'b0 || ena !== 1'b1 || rsp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL rst_seq k=%0d iw[1:0]=%b ena=%b rsp_valid=%b want iw[1:0]=0%b ena=1 rsp_valid=0",
                 k, iw[1:0], ena, rsp_valid, exp0);
      end
      @(negedge clk);
    end
    nvec++;
    if (rsp_valid !== 1'b1 || iw[1:0] !== 2'b10 || rsp_data !== 24'hC30000) begin
      nerr++;
      $display("FAIL rst_done rsp_valid=%b iw[1:0]=%b rsp_data=%h want 1/10/c30000",
               rsp_valid, iw[1:0], rsp_data);
    end
    handshake();
  endtask

  task automatic test_step();
    int cyc;
    send_cmd(2'b10, 8'hA5, 8'h3C, 8'd3);
    nvec++;
    if (iw[17:2] !== 16'h3CA5 || iw[0] !== 1'b1) begin
      nerr++;
      $display("FAIL step_inputs iw[17:2]=%h iw[0]=%b want 3ca5/1", iw[17:2], iw[0]);
    end
    wait_rsp(100, cyc);
    nvec++;
    if (rsp_valid !== 1'b1 || cyc != 3 * 2 * DIV) begin
      nerr++;
      $display("FAIL step_latency rsp_valid=%b cycles=%0d want 1/%0d", rsp_valid, cyc, 3 * 2 * DIV);
    end
    nvec++;
    if (rsp_data !== 24'hC3A503 || iw[0] !== 1'b0) begin
      nerr++;
      $display("FAIL step_data rsp_data=%h iw[0]=%b want c3a503/0", rsp_data, iw[0]);
    end
    handshake();
  endtask

  task automatic test_step_zero();
    send_cmd(2'b10, 8'h11, 8'h22, 8'd0);
    for (int k = 0; k < DIV; k++) begin
      nvec++;
      if (iw[0] !== 1'b0 || iw[9:2] !== 8'h11 || rsp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL zero_wait k=%0d iw[0]=%b ui=%h rsp_valid=%b want 0/11/0",
                 k, iw[0], iw[9:2], rsp_valid);
      end
      @(negedge clk);
    end
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_data !== 24'hC31103 || iw[0] !== 1'b0) begin
      nerr++;
      $display("FAIL zero_rsp rsp_valid=%b rsp_data=%h iw[0]=%b want 1/c31103/0",
               rsp_valid, rsp_data, iw[0]);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc;
    send_cmd(2'b00, 8'h00, 8'h00, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_ui    = 8'h77;
    cmd_uio   = 8'h00;
    cmd_count = 8'd0;
    for (int k = 0; k < 10; k++) begin
      nvec++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== 24'hC31103 || iw[9:2] !== 8'h11) begin
        nerr++;
        $display("FAIL hold k=%0d rsp_valid=%b cmd_ready=%b rsp_data=%h ui=%h want 1/0/c31103/11",
                 k, rsp_valid, cmd_ready, rsp_data, iw[9:2]);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    nvec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 24'hC31103) begin
      nerr++;
      $display("FAIL after_hs rsp_valid=%b cmd_ready=%b rsp_data=%h want 0/1/c31103",
               rsp_valid, cmd_ready, rsp_data);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    nvec++;
    if (iw[9:2] !== 8'h77 || cmd_ready !== 1'b0) begin
      nerr++;
      $display("FAIL pending_accept ui=%h cmd_ready=%b want 77/0", iw[9:2], cmd_ready);
    end
    wait_rsp(20, cyc);
    nvec++;
    if (rsp_valid !== 1'b1 || cyc != DIV || rsp_data !== 24'hC37703) begin
      nerr++;
      $display("FAIL pending_rsp rsp_valid=%b cycles=%0d rsp_data=%h want 1/%0d/c37703",
               rsp_valid, cyc, rsp_data, DIV);
    end
    handshake();
  endtask

  task automatic test_abort();
    send_cmd(2'b10, 8'h01, 8'h02, 8'd200);
    @(negedge clk);
    nvec++;
    if (iw[0] !== 1'b1 || ena !== 1'b1) begin
      nerr++;
      $display("FAIL abort_pre iw[0]=%b ena=%b want 1/1", iw[0], ena);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if (iw !== 18'h0 || ena !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 24'h0) begin
      nerr++;
      $display("FAIL abort_async iw=%h ena=%b rsp_valid=%b rsp_data=%h want 0/0/0/0",
               iw, ena, rsp_valid, rsp_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvec++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || iw !== 18'h0) begin
        nerr++;
        $display("FAIL abort_idle k=%0d cmd_ready=%b rsp_valid=%b iw=%h want 1/0/0",
                 k, cmd_ready, rsp_valid, iw);
      end
    end
  endtask

  task automatic test_step_max();
    int cyc;
    send_cmd(2'b01, 8'h00, 8'h00, 8'h00);
    wait_rsp(100, cyc);
    handshake();
    send_cmd(2'b10, 8'h00, 8'h00, 8'd255);
    wait_rsp(1100, cyc);
    nvec++;
    if (rsp_valid !== 1'b1 || cyc != 255 * 2 * DIV || rsp_data !== 24'hC300FF) begin
      nerr++;
      $display("FAIL step_max rsp_valid=%b cycles=%0d rsp_data=%h want 1/%0d/c300ff",
               rsp_valid, cyc, rsp_data, 255 * 2 * DIV);
    end
    handshake();
  endtask

  task automatic test_disable();
    int cyc;
    send_cmd(2'b01, 8'h00, 8'h00, 8'h00);
    wait_rsp(100, cyc);
    handshake();
    send_cmd(2'b10, 8'h5A, 8'h00, 8'd2);
    wait_rsp(100, cyc);
    nvec++;
    if (rsp_valid !== 1'b1 || cyc != 2 * 2 * DIV || rsp_data !== 24'hC35A02) begin
      nerr++;
      $display("FAIL pre_disable rsp_valid=%b cycles=%0d rsp_data=%h want 1/%0d/c35a02",
               rsp_valid, cyc, rsp_data, 2 * 2 * DIV);
    end
    handshake();
    send_cmd(2'b11, 8'h00, 8'h00, 8'h00);
    nvec++;
    if (ena !== 1'b0 || iw !== 18'h0 || rsp_valid !== 1'b1 || rsp_data !== 24'hC35A02) begin
      nerr++;
      $display("FAIL disable ena=%b iw=%h rsp_valid=%b rsp_data=%h want 0/0/1/c35a02",
               ena, iw, rsp_valid, rsp_data);
    end
    handshake();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        nerr++;
        $display("FAIL single_rsp k=%0d rsp_valid=%b cmd_ready=%b want 0/1", k, rsp_valid, cmd_ready);
      end
      @(negedge clk);
    end
    send_cmd(2'b00, 8'h00, 8'h00, 8'h00);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_data !== 24'hC30000 || ena !== 1'b0 || iw !== 18'h0) begin
      nerr++;
      $display("FAIL sample_after rsp_valid=%b rsp_data=%h ena=%b iw=%h want 1/c30000/0/0",
               rsp_valid, rsp_data, ena, iw);
    end
    handshake();
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_ui    = 8'h00;
    cmd_uio   = 8'h00;
    cmd_count = 8'h00;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_cmd();
    test_step();
    test_step_zero();
    test_back_to_back();
    test_abort();
    test_step_max();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
